// File: rtl/countup_pkg.sv
// Shared types and constants for the count-up timer: FSM state encoding,
// BCD digit type and the active-low 7-segment digit table.
package countup_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG7 [0:9] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000  // 9
    };

    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes blank the digit.
module seg7_decoder
    import countup_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG7_BLANK;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG7[bcd_i];
        end
    end

endmodule

// File: rtl/countup_timer.sv
// N-bit count-up timer with prescaler, terminal flag and two-digit 7-segment output.
// Default build saturates at 2^N-1; define COUNTUP_WRAP_EN to wrap to 0 instead.
module countup_timer
    import countup_pkg::*;
#(
    parameter int N        = 6,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [N-1:0] count,
    output logic         done,
    output logic [6:0]   display1,
    output logic [6:0]   display2,
    output state_t       dbg_state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N-1:0]  COUNT_MAX = {N{1'b1}};
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    bcd_t          ones_q, ones_d;
    bcd_t          tens_q, tens_d;
    logic          done_q, done_d;
    logic          active;
    logic          tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            done_q  <= done_d;
        end
    end

    // Counting starts on the same edge that moves IDLE to RUN, so en has no
    // start-up latency; DONE freezes the prescaler and the count.
    assign active = en && (state_q != DONE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        done_d  = done_q;
        tick    = 1'b0;

        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
            ones_d  = '0;
            tens_d  = '0;
            done_d  = 1'b0;
        end else begin
            if (active) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    tick  = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end

            case (state_q)
                IDLE:    if (en)  state_d = RUN;
                RUN:     if (!en) state_d = IDLE;
                default: state_d = state_q;
            endcase

            if (tick) begin
                count_d = count_q + 1'b1;
                if (count_q == COUNT_MAX) begin
                    ones_d = '0;
                    tens_d = '0;
                end else if (ones_q == 4'd9) begin
                    ones_d = '0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
`ifndef COUNTUP_WRAP_EN
                if (count_d == COUNT_MAX) begin
                    state_d = DONE;
                end
`endif
            end

            done_d = (count_d == COUNT_MAX);
        end
    end

    seg7_decoder u_dec_ones (
        .bcd_i (ones_q),
        .seg_o (display1)
    );

    seg7_decoder u_dec_tens (
        .bcd_i (tens_q),
        .seg_o (display2)
    );

    assign count     = count_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_countup_timer.sv
// Directed bench for countup_timer: three instances (N=4/P=1, N=4/P=3, N=6/P=1)
// share one set of inputs; each phase resets and then checks one instance.
module tb_countup_timer;
    import countup_pkg::*;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic clk;
    logic reset;
    logic en;
    logic clr;

    logic [3:0] count_a, count_b;
    logic [5:0] count_c;
    logic       done_a, done_b, done_c;
    logic [6:0] d1_a, d2_a, d1_b, d2_b, d1_c, d2_c;
    state_t     st_a, st_b, st_c;

    int n_cmp = 0;
    int n_err = 0;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    countup_timer #(.N(4), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .count(count_a), .done(done_a), .display1(d1_a), .display2(d2_a),
        .dbg_state(st_a)
    );

    countup_timer #(.N(4), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .count(count_b), .done(done_b), .display1(d1_b), .display2(d2_b),
        .dbg_state(st_b)
    );

    countup_timer #(.N(6), .PRESCALE(1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .count(count_c), .done(done_c), .display1(d1_c), .display2(d2_c),
        .dbg_state(st_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: advance n rising edges, then settle 1 time unit past the edge
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        edges(n);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;

        // reset state
        do_reset(2);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_d1",    32'(d1_a),    32'(S0));
        check("rst_d2",    32'(d2_a),    32'(S0));
        check("rst_state", 32'(st_a),    32'(IDLE));

        // count to terminal
        en = 1'b1;
        edges(14);
        check("c14_count", 32'(count_a), 32'd14);
        check("c14_done",  32'(done_a),  32'd0);
        edges(1);
        check("c15_count", 32'(count_a), 32'd15);
        check("c15_done",  32'(done_a),  32'd1);
        check("c15_d1",    32'(d1_a),    32'(S5));
        check("c15_d2",    32'(d2_a),    32'(S1));
`ifdef COUNTUP_WRAP_EN
        edges(1);
        check("wrap16_count", 32'(count_a), 32'd0);
        check("wrap16_done",  32'(done_a),  32'd0);
        check("wrap16_d1",    32'(d1_a),    32'(S0));
        check("wrap16_d2",    32'(d2_a),    32'(S0));
        edges(1);
        check("wrap17_count", 32'(count_a), 32'd1);
        check("wrap17_done",  32'(done_a),  32'd0);
`else
        check("c15_state", 32'(st_a), 32'(DONE));
        edges(5);
        check("sat_count", 32'(count_a), 32'd15);
        check("sat_done",  32'(done_a),  32'd1);
        check("sat_d1",    32'(d1_a),    32'(S5));
`endif

        // enable hold, clear, reset mid-count
        do_reset(1);
        en = 1'b1;
        edges(7);
        check("en7_count", 32'(count_a), 32'd7);
        en = 1'b0;
        edges(4);
        check("hold_count", 32'(count_a), 32'd7);
        check("hold_state", 32'(st_a),    32'(IDLE));
        en = 1'b1;
        edges(1);
        check("resume_count", 32'(count_a), 32'd8);
        check("resume_d1",    32'(d1_a),    32'(S8));
        edges(1);
        check("pre_clr_count", 32'(count_a), 32'd9);
        clr = 1'b1;
        edges(1);
        check("clr_count", 32'(count_a), 32'd0);
        check("clr_state", 32'(st_a),    32'(IDLE));
        clr = 1'b0;
        edges(1);
        check("post_clr_count", 32'(count_a), 32'd1);
        edges(8);
        check("c9_count", 32'(count_a), 32'd9);
        check("c9_d1",    32'(d1_a),    32'(S9));
        check("c9_d2",    32'(d2_a),    32'(S0));
        edges(1);
        check("c10_d1", 32'(d1_a), 32'(S0));
        check("c10_d2", 32'(d2_a), 32'(S1));
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        check("midrst_count", 32'(count_a), 32'd0);
        check("midrst_d1",    32'(d1_a),    32'(S0));
        check("midrst_d2",    32'(d2_a),    32'(S0));

        // prescaled instance: count advances on every third edge
        do_reset(1);
        en = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            edges(1);
            check($sformatf("pre_e%0d", e), 32'(count_b), 32'(e / 3));
        end
        check("pre_d1", 32'(d1_b), 32'(S3));

        // 6-bit instance to its terminal count
        do_reset(1);
        en = 1'b1;
        edges(63);
        check("n6_count", 32'(count_c), 32'd63);
        check("n6_done",  32'(done_c),  32'd1);
        check("n6_d1",    32'(d1_c),    32'(S3));
        check("n6_d2",    32'(d2_c),    32'(S6));

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
